dmx_cpu_responder: RTL and testbench

DMX_CPU_RESPONDER -- requirements
Module: dmx_cpu_responder

---
 rtl/dmx_cpu_responder.sv | 162 ++++++++++++++++
 tb/tb_dmx_cpu_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmx_cpu_responder.sv
// CPU-side responder for the FP32 unit: issues legal FP32 instructions, tracks
// outstanding transaction ids in order, and answers illegal instructions locally.
module dmx_cpu_responder #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [4:0]  instr_opcode,
  input  logic [1:0]  instr_fmt,
  input  logic [63:0] src0_data,
  input  logic [63:0] src1_data,
  input  logic [63:0] src2_data,
  input  logic [3:0]  cpu_tid,
  input  logic [2:0]  csr_rounding_mode,
  input  logic        csr_tininess_mode,
  output logic        cpu_req_ready,
  output logic        cpu_resp_valid,
  output logic [3:0]  cpu_resp_tid,
  output logic [63:0] cpu_resp_data,
  output logic [4:0]  cpu_resp_flags,
  output logic        fp32_req_valid,
  input  logic        fp32_req_ready,
  output logic [7:0]  fp32_ctrl,
  output logic [31:0] fp32_a,
  output logic [31:0] fp32_b,
  output logic [31:0] fp32_c,
  output logic [2:0]  fp32_rounding_mode,
  output logic        fp32_tininess_mode,
  input  logic        fp32_resp_valid,
  input  logic [31:0] fp32_result,
  input  logic [4:0]  fp32_flags,
  output logic        resp_orphan
);

  localparam logic [4:0]  OPC_NOP  = 5'd0;
  localparam logic [1:0]  FMT_FP32 = 2'd0;
  localparam logic [63:0] NAN_BOX  = 64'hFFFFFFFF_7FC00000;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, ILLRESP} state_t;

  state_t         state;
  logic [3:0]     tag_mem [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [3:0]     hold_tid;
  logic           out_of_reset;
  logic           is_nop;
  logic           is_legal;
  logic           is_illegal;
  logic           accept;
  logic           push;
  logic           pop;
  logic           orphan_hit;
  logic           unused_src_hi;

  assign is_nop     = (instr_opcode == OPC_NOP);
  assign is_legal   = (instr_fmt == FMT_FP32) && !is_nop;
  assign is_illegal = !is_nop && !is_legal;

  // Illegal ops wait for an empty FIFO so their local answer cannot overtake FP32 results.
  always_comb begin
    cpu_req_ready = 1'b0;
    if (!reset && out_of_reset && state == IDLE)
      cpu_req_ready = is_nop || (is_legal && count < DEPTH_C) || (is_illegal && count == '0);
  end

  assign accept     = instr_valid && cpu_req_ready;
  assign push       = fp32_req_valid && fp32_req_ready;
  assign pop        = fp32_resp_valid && (count != '0);
  assign orphan_hit = fp32_resp_valid && (count == '0);

  assign unused_src_hi = ^{src0_data[63:32], src1_data[63:32], src2_data[63:32]};

  always_ff @(posedge clock) begin
    if (push)
      tag_mem[wr_ptr] <= hold_tid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      out_of_reset       <= 1'b0;
      fp32_req_valid     <= 1'b0;
      fp32_ctrl          <= '0;
      fp32_a             <= '0;
      fp32_b             <= '0;
      fp32_c             <= '0;
      fp32_rounding_mode <= '0;
      fp32_tininess_mode <= 1'b0;
      hold_tid           <= '0;
      cpu_resp_valid     <= 1'b0;
      cpu_resp_tid       <= '0;
      cpu_resp_data      <= '0;
      cpu_resp_flags     <= '0;
      resp_orphan        <= 1'b0;
    end else begin
      out_of_reset   <= 1'b1;
      cpu_resp_valid <= 1'b0;
      if (orphan_hit)
        resp_orphan <= 1'b1;
      if (pop) begin
        cpu_resp_valid <= 1'b1;
        cpu_resp_tid   <= tag_mem[rd_ptr];
        cpu_resp_data  <= {32'hFFFFFFFF, fp32_result};
        cpu_resp_flags <= fp32_flags;
      end
      case (state)
        IDLE: begin
          if (accept && is_legal) begin
            fp32_ctrl          <= {3'b000, instr_opcode};
            fp32_a             <= src0_data[31:0];
            fp32_b             <= src1_data[31:0];
            fp32_c             <= src2_data[31:0];
            fp32_rounding_mode <= csr_rounding_mode;
            fp32_tininess_mode <= csr_tininess_mode;
            hold_tid           <= cpu_tid;
            fp32_req_valid     <= 1'b1;
            state              <= ISSUE;
          end else if (accept && is_illegal) begin
            cpu_resp_valid <= 1'b1;
            cpu_resp_tid   <= cpu_tid;
            cpu_resp_data  <= NAN_BOX;
            cpu_resp_flags <= 5'b10000;
            state          <= ILLRESP;
          end
        end
        ISSUE: begin
          if (fp32_req_ready) begin
            fp32_req_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        ILLRESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmx_cpu_responder.sv
// Directed and randomized bench for dmx_cpu_responder with an in-order tag queue
// reference model; every check is an immediate assertion.
module tb_dmx_cpu_responder;

  localparam int          TAG_DEPTH = 4;
  localparam logic [4:0]  OPC_NOP   = 5'd0;
  localparam logic [1:0]  FMT_FP32  = 2'd0;
  localparam logic [63:0] NAN_BOX   = 64'hFFFFFFFF_7FC00000;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [4:0]  instr_opcode;
  logic [1:0]  instr_fmt;
  logic [63:0] src0_data, src1_data, src2_data;
  logic [3:0]  cpu_tid;
  logic [2:0]  csr_rounding_mode;
  logic        csr_tininess_mode;
  logic        cpu_req_ready;
  logic        cpu_resp_valid;
  logic [3:0]  cpu_resp_tid;
  logic [63:0] cpu_resp_data;
  logic [4:0]  cpu_resp_flags;
  logic        fp32_req_valid;
  logic        fp32_req_ready;
  logic [7:0]  fp32_ctrl;
  logic [31:0] fp32_a, fp32_b, fp32_c;
  logic [2:0]  fp32_rounding_mode;
  logic        fp32_tininess_mode;
  logic        fp32_resp_valid;
  logic [31:0] fp32_result;
  logic [4:0]  fp32_flags;
  logic        resp_orphan;

  int compared = 0;
  int mismatched = 0;

  // Reference model: outstanding tids in issue order plus the last visible response.
  logic [3:0]  tag_q[$];
  logic [3:0]  last_tid;
  logic [63:0] last_data;
  logic [4:0]  last_flags;
  logic        orphan_exp;

  dmx_cpu_responder #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_opcode(instr_opcode), .instr_fmt(instr_fmt),
    .src0_data(src0_data), .src1_data(src1_data), .src2_data(src2_data),
    .cpu_tid(cpu_tid), .csr_rounding_mode(csr_rounding_mode), .csr_tininess_mode(csr_tininess_mode),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_resp_tid(cpu_resp_tid),
    .cpu_resp_data(cpu_resp_data), .cpu_resp_flags(cpu_resp_flags),
    .fp32_req_valid(fp32_req_valid), .fp32_req_ready(fp32_req_ready), .fp32_ctrl(fp32_ctrl),
    .fp32_a(fp32_a), .fp32_b(fp32_b), .fp32_c(fp32_c),
    .fp32_rounding_mode(fp32_rounding_mode), .fp32_tininess_mode(fp32_tininess_mode),
    .fp32_resp_valid(fp32_resp_valid), .fp32_result(fp32_result), .fp32_flags(fp32_flags),
    .resp_orphan(resp_orphan)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] opc, input logic [1:0] fmt, input logic [3:0] tid);
    instr_valid  = valid;
    instr_opcode = opc;
    instr_fmt    = fmt;
    cpu_tid      = tid;
    #1;
  endtask

  task automatic random_srcs;
    src0_data = {$urandom, $urandom};
    src1_data = {$urandom, $urandom};
    src2_data = {$urandom, $urandom};
    csr_rounding_mode = 3'($urandom_range(0, 7));
    csr_tininess_mode = 1'($urandom_range(0, 1));
  endtask

  function automatic logic exp_ready(input logic [4:0] opc, input logic [1:0] fmt);
    if (opc == OPC_NOP) return 1'b1;
    if (fmt == FMT_FP32) return tag_q.size() < TAG_DEPTH;
    return tag_q.size() == 0;
  endfunction

  task automatic probe_idle(input string tag);
    logic [4:0] opc;
    logic [1:0] bad_fmt;
    opc = 5'($urandom_range(1, 31));
    bad_fmt = 2'($urandom_range(1, 3));
    applyStimulus(1'b0, opc, FMT_FP32, 4'd0);
    checkOutput({tag, "_legal_ready"}, 64'(cpu_req_ready), 64'(exp_ready(opc, FMT_FP32)));
    applyStimulus(1'b0, opc, bad_fmt, 4'd0);
    checkOutput({tag, "_illegal_ready"}, 64'(cpu_req_ready), 64'(exp_ready(opc, bad_fmt)));
    tick;
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] res, input logic [4:0] flg);
    if (tag_q.size() > 0) begin
      last_tid   = tag_q.pop_front();
      last_data  = {32'hFFFFFFFF, res};
      last_flags = flg;
      checkOutput({tag, "_valid"}, 64'(cpu_resp_valid), 64'd1);
    end else begin
      orphan_exp = 1'b1;
      checkOutput({tag, "_orphan_novalid"}, 64'(cpu_resp_valid), 64'd0);
    end
    checkOutput({tag, "_tid"}, 64'(cpu_resp_tid), 64'(last_tid));
    checkOutput({tag, "_data"}, cpu_resp_data, last_data);
    checkOutput({tag, "_flags"}, 64'(cpu_resp_flags), 64'(last_flags));
    checkOutput({tag, "_orphan"}, 64'(resp_orphan), 64'(orphan_exp));
  endtask

  task automatic check_pulse_end(input string tag);
    checkOutput({tag, "_end_valid"}, 64'(cpu_resp_valid), 64'd0);
    checkOutput({tag, "_hold_data"}, cpu_resp_data, last_data);
    checkOutput({tag, "_hold_tid"}, 64'({cpu_resp_tid, cpu_resp_flags}), 64'({last_tid, last_flags}));
  endtask

  task automatic send_resp(input logic [31:0] res, input logic [4:0] flg);
    fp32_result = res;
    fp32_flags = flg;
    fp32_resp_valid = 1'b1;
    tick;
    fp32_resp_valid = 1'b0;
    fp32_result = $urandom;
    expect_resp("resp", res, flg);
    tick;
    check_pulse_end("resp");
  endtask

  task automatic issue_legal(input logic [3:0] tid, input logic [31:0] a, input logic [31:0] b, input int stall,
                             input logic resp_same, input logic [31:0] res, input logic [4:0] flg);
    logic [4:0]  opc;
    logic [31:0] exp_a, exp_b;
    logic [43:0] exp_misc;
    opc = 5'($urandom_range(1, 31));
    random_srcs();
    src0_data[31:0] = a;
    src1_data[31:0] = b;
    exp_a = a;
    exp_b = b;
    exp_misc = {src2_data[31:0], 3'b000, opc, csr_rounding_mode, csr_tininess_mode};
    applyStimulus(1'b1, opc, FMT_FP32, tid);
    checkOutput("legal_ready", 64'(cpu_req_ready), 64'(exp_ready(opc, FMT_FP32)));
    tick;
    instr_valid = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      random_srcs();
      if (i == stall) begin
        fp32_req_ready = 1'b1;
        if (resp_same) begin
          fp32_resp_valid = 1'b1;
          fp32_result = res;
          fp32_flags = flg;
        end
      end
      #1;
      checkOutput("issue_req_valid", 64'(fp32_req_valid), 64'd1);
      checkOutput("issue_ab", {fp32_a, fp32_b}, {exp_a, exp_b});
      checkOutput("issue_c_ctrl_modes", 64'({fp32_c, fp32_ctrl, fp32_rounding_mode, fp32_tininess_mode}), 64'(exp_misc));
      checkOutput("issue_not_ready", 64'(cpu_req_ready), 64'd0);
      tick;
    end
    fp32_req_ready = 1'b0;
    fp32_resp_valid = 1'b0;
    if (resp_same) expect_resp("same_cycle", res, flg);
    tag_q.push_back(tid);
    checkOutput("issue_done_req_valid", 64'(fp32_req_valid), 64'd0);
    if (resp_same) begin
      tick;
      check_pulse_end("same_cycle");
    end
  endtask

  task automatic issue_illegal(input logic [3:0] tid, input logic [1:0] fmt);
    logic [4:0] opc;
    opc = 5'($urandom_range(1, 31));
    random_srcs();
    applyStimulus(1'b1, opc, fmt, tid);
    checkOutput("illegal_ready", 64'(cpu_req_ready), 64'(exp_ready(opc, fmt)));
    tick;
    instr_valid = 1'b0;
    last_tid   = tid;
    last_data  = NAN_BOX;
    last_flags = 5'b10000;
    checkOutput("illegal_valid", 64'(cpu_resp_valid), 64'd1);
    checkOutput("illegal_tid", 64'(cpu_resp_tid), 64'(tid));
    checkOutput("illegal_data", cpu_resp_data, NAN_BOX);
    checkOutput("illegal_flags", 64'(cpu_resp_flags), 64'(5'b10000));
    checkOutput("illegal_no_fp32_req", 64'(fp32_req_valid), 64'd0);
    checkOutput("illresp_not_ready", 64'(cpu_req_ready), 64'd0);
    tick;
    check_pulse_end("illegal");
    checkOutput("illegal_after_no_fp32_req", 64'(fp32_req_valid), 64'd0);
  endtask

  task automatic issue_nop;
    applyStimulus(1'b1, OPC_NOP, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    checkOutput("nop_ready", 64'(cpu_req_ready), 64'd1);
    tick;
    instr_valid = 1'b0;
    checkOutput("nop_no_resp", 64'(cpu_resp_valid), 64'd0);
    checkOutput("nop_no_fp32_req", 64'(fp32_req_valid), 64'd0);
    probe_idle("nop_idle");
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_ready"}, 64'(cpu_req_ready), 64'd0);
    checkOutput({tag, "_resp_valid"}, 64'(cpu_resp_valid), 64'd0);
    checkOutput({tag, "_req_valid"}, 64'(fp32_req_valid), 64'd0);
    checkOutput({tag, "_ctrl_modes"}, 64'({fp32_ctrl, fp32_rounding_mode, fp32_tininess_mode}), 64'd0);
    checkOutput({tag, "_ab"}, {fp32_a, fp32_b}, 64'd0);
    checkOutput({tag, "_c"}, 64'(fp32_c), 64'd0);
    checkOutput({tag, "_resp_tid_flags"}, 64'({cpu_resp_tid, cpu_resp_flags}), 64'd0);
    checkOutput({tag, "_resp_data"}, cpu_resp_data, 64'd0);
    checkOutput({tag, "_orphan"}, 64'(resp_orphan), 64'd0);
  endtask

  task automatic model_reset;
    tag_q.delete();
    last_tid = '0;
    last_data = '0;
    last_flags = '0;
    orphan_exp = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr_opcode = '0;
    instr_fmt = '0;
    cpu_tid = '0;
    fp32_req_ready = 1'b0;
    fp32_resp_valid = 1'b0;
    fp32_result = '0;
    fp32_flags = '0;
    random_srcs();
    model_reset();

    // Power-on reset with a NOP offered: ready must stay low while reset is high.
    tick;
    tick;
    applyStimulus(1'b1, OPC_NOP, FMT_FP32, 4'd1);
    tick;
    check_reset_values("por");
    reset = 1'b0;
    instr_valid = 1'b0;
    tick;
    probe_idle("post_por");

    // Single operation with known operands.
    issue_legal(4'd3, 32'h3F800000, 32'h40000000, 0, 1'b0, 32'h0, 5'h0);
    send_resp(32'h40400000, 5'b00000);
    checkOutput("single_data", last_data, 64'hFFFFFFFF_40400000);

    // Backpressure, then fill the tag FIFO.
    issue_legal(4'd1, $urandom, $urandom, 5, 1'b0, 32'h0, 5'h0);
    issue_legal(4'd2, $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    issue_legal(4'd3, $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    issue_legal(4'd4, $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    applyStimulus(1'b1, 5'd3, FMT_FP32, 4'd5);
    checkOutput("full_not_ready", 64'(cpu_req_ready), 64'd0);
    tick;
    instr_valid = 1'b0;
    #1;
    checkOutput("full_not_accepted", 64'(fp32_req_valid), 64'd0);
    send_resp($urandom, 5'b00001);
    probe_idle("after_full_pop");
    issue_legal(4'd5, $urandom, $urandom, 1, 1'b0, 32'h0, 5'h0);
    for (int i = 0; i < 4; i++) send_resp($urandom, 5'($urandom_range(0, 31)));

    // Ordering of four, then push and pop on the same edge.
    for (int t = 1; t <= 4; t++) issue_legal(4'(t), $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    for (int i = 0; i < 4; i++) begin
      send_resp($urandom, 5'($urandom_range(0, 31)));
      checkOutput("order_tid", 64'(last_tid), 64'(i + 1));
    end
    issue_legal(4'd8, $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    issue_legal(4'd9, $urandom, $urandom, 2, 1'b1, 32'h12345678, 5'b00110);
    probe_idle("same_cycle_count1");
    send_resp($urandom, 5'b01000);
    probe_idle("same_cycle_drained");

    // Illegal instruction must wait for the FIFO to drain.
    issue_legal(4'd10, $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    issue_legal(4'd11, $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    random_srcs();
    applyStimulus(1'b1, 5'h0A, 2'b01, 4'd7);
    checkOutput("illegal_wait_cnt2", 64'(cpu_req_ready), 64'd0);
    send_resp($urandom, 5'b00000);
    applyStimulus(1'b1, 5'h0A, 2'b01, 4'd7);
    checkOutput("illegal_wait_cnt1", 64'(cpu_req_ready), 64'd0);
    instr_valid = 1'b0;
    send_resp($urandom, 5'b00000);
    issue_illegal(4'd7, 2'b01);

    // NOP is dropped; a response with nothing outstanding is an orphan.
    issue_nop();
    send_resp($urandom, 5'b11111);
    tick;
    checkOutput("orphan_sticky", 64'(resp_orphan), 64'd1);

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4 && tag_q.size() < TAG_DEPTH)
        issue_legal(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 2)),
                    (tag_q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom, 5'($urandom_range(0, 31)));
      else if (sel < 7 && tag_q.size() > 0)
        send_resp($urandom, 5'($urandom_range(0, 31)));
      else if (sel == 7)
        issue_nop();
      else if (tag_q.size() == 0)
        issue_illegal(4'($urandom_range(0, 15)), 2'($urandom_range(1, 3)));
      else
        probe_idle("rand_probe");
    end
    while (tag_q.size() > 0) send_resp($urandom, 5'($urandom_range(0, 31)));

    // Reset while a request is held in ISSUE with two tags outstanding.
    issue_legal(4'd12, $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    issue_legal(4'd13, $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    random_srcs();
    applyStimulus(1'b1, 5'd5, FMT_FP32, 4'd14);
    tick;
    instr_valid = 1'b0;
    checkOutput("pre_reset_issue", 64'(fp32_req_valid), 64'd1);
    reset = 1'b1;
    tick;
    check_reset_values("mid_reset");
    reset = 1'b0;
    model_reset();
    fp32_result = $urandom;
    fp32_flags = 5'b00011;
    fp32_resp_valid = 1'b1;
    tick;
    fp32_resp_valid = 1'b0;
    expect_resp("post_reset_orphan", fp32_result, fp32_flags);
    probe_idle("post_reset");
    issue_legal(4'd6, $urandom, $urandom, 0, 1'b0, 32'h0, 5'h0);
    send_resp(32'hC0000000, 5'b00001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
